// File: rtl/ddr3_axi_memtest_if.sv
// AXI4 write/read channel bundle between the memory tester and the DDR3 slave port.
// A beat transfers on a rising edge where valid and ready are both high; a source holds valid and payload until then.
interface ddr3_axi_memtest_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/ddr3_axi_memtest.sv
// DDR3 bring-up tester: writes an address-derived pattern with INCR bursts, reads it back
// and reports pass/fail, a saturating error count and the first failing byte address.
module ddr3_axi_memtest #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          NUM_BURSTS = 16,
    parameter int          BURST_LEN  = 8,
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter logic [31:0] PATTERN    = 32'hA5A5_5A5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,
    output logic [2:0]  dbg_state,
    ddr3_axi_memtest_if.master axi4
);
    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

    localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
    localparam logic [31:0] STRIDE     = 32'(BURST_LEN * 4);

    state_t      state, state_next;
    logic [15:0] burst_cnt;
    logic [7:0]  beat_cnt;
    logic [31:0] burst_addr, beat_addr, exp_data, err_addr;
    logic        last_beat, last_burst, accept_start;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    logic        w_fire, r_fire, b_fire;
    logic        unused_ids;

    assign beat_addr  = burst_addr + {22'd0, beat_cnt, 2'b00};
    assign exp_data   = {beat_addr[31:2], 2'b00} ^ PATTERN;
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign last_burst = (burst_cnt == LAST_BURST);
    assign err_sum    = {1'b0, err_count} + {15'd0, err_inc};
    assign w_fire     = (state == WDATA) && axi4.wready;
    assign r_fire     = (state == RDATA) && axi4.rvalid;
    assign b_fire     = (state == WRESP) && axi4.bvalid;
    assign unused_ids = ^{axi4.bid, axi4.rid};

    assign axi4.awid    = AXI_ID;
    assign axi4.arid    = AXI_ID;
    assign axi4.awaddr  = burst_addr;
    assign axi4.araddr  = burst_addr;
    assign axi4.awlen   = LAST_BEAT;
    assign axi4.arlen   = LAST_BEAT;
    assign axi4.awburst = 2'b01;
    assign axi4.arburst = 2'b01;
    assign axi4.wstrb   = 4'hF;
    assign axi4.wdata   = axi4.wvalid ? exp_data : 32'd0;

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == 16'd0);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        axi4.awvalid = 1'b0;
        axi4.wvalid  = 1'b0;
        axi4.wlast   = 1'b0;
        axi4.bready  = 1'b0;
        axi4.arvalid = 1'b0;
        axi4.rready  = 1'b0;
        err_inc      = 2'd0;
        err_addr     = beat_addr;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = WADDR;
                end
            end
            WADDR: begin
                axi4.awvalid = 1'b1;
                if (axi4.awready) state_next = WDATA;
            end
            WDATA: begin
                axi4.wvalid = 1'b1;
                axi4.wlast  = last_beat;
                if (axi4.wready && last_beat) state_next = WRESP;
            end
            WRESP: begin
                axi4.bready = 1'b1;
                if (axi4.bvalid) begin
                    if (axi4.bresp != 2'b00) begin
                        err_inc  = 2'd1;
                        err_addr = burst_addr;
                    end
                    state_next = last_burst ? RADDR : WADDR;
                end
            end
            RADDR: begin
                axi4.arvalid = 1'b1;
                if (axi4.arready) state_next = RDATA;
            end
            RDATA: begin
                axi4.rready = 1'b1;
                if (axi4.rvalid) begin
                    // Data/response fault and an rlast disagreement are separate errors on one beat.
                    err_inc = {1'b0, (axi4.rdata != exp_data) || (axi4.rresp != 2'b00)}
                            + {1'b0, axi4.rlast != last_beat};
                    if (last_beat) state_next = last_burst ? DONE : RADDR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count      <= 16'd0;
            first_err_addr <= 32'd0;
            burst_cnt      <= 16'd0;
            beat_cnt       <= 8'd0;
            burst_addr     <= 32'd0;
        end else if (accept_start) begin
            err_count      <= 16'd0;
            first_err_addr <= 32'd0;
            burst_cnt      <= 16'd0;
            beat_cnt       <= 8'd0;
            burst_addr     <= BASE_ADDR;
        end else begin
            if (err_inc != 2'd0) begin
                err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                if (err_count == 16'd0) first_err_addr <= err_addr;
            end
            if (w_fire || r_fire) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
            // Burst address wraps back to the base between the write and read phases.
            if (b_fire || (r_fire && last_beat)) begin
                if (last_burst) begin
                    burst_cnt  <= 16'd0;
                    burst_addr <= BASE_ADDR;
                end else begin
                    burst_cnt  <= burst_cnt + 16'd1;
                    burst_addr <= burst_addr + STRIDE;
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr3_axi_memtest.sv
// Directed bench for ddr3_axi_memtest: a table of slave fault scenarios with expected
// results, plus hand-written sequences for start handling and asynchronous reset.
module tb_ddr3_axi_memtest;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] PAT  = 32'hA5A5_5A5A;
    localparam int          NB   = 2;
    localparam int          BL   = 4;
    localparam int          TMO  = 100;

    typedef struct {
        bit          stall;
        int          corrupt;
        int          bresp_burst;
        int          rresp_beat;
        int          rlast_flip;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
        logic        exp_pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic [2:0]  dbg_state;

    ddr3_axi_memtest_if axi();

    ddr3_axi_memtest #(
        .BASE_ADDR(BASE), .NUM_BURSTS(NB), .BURST_LEN(BL), .AXI_ID(4'h3), .PATTERN(PAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .dbg_state(dbg_state),
        .axi4(axi)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit tmo;
    logic [31:0] exp_q[$];
    vec_t vecs[8];
    vec_t clean_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ PAT;
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0:       return axi.awvalid;
            1:       return axi.wvalid;
            2:       return axi.arvalid;
            3:       return axi.rready;
            default: return done;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w);
        int n = 0;
        while (sig(w) !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sig(w) !== 1'b1) begin
            errors++;
            tmo = 1'b1;
            $display("FAIL timeout_%s: got low after %0d cycles expected high", name, n);
        end
    endtask

    // driver tasks
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_awvalid", {31'd0, axi.awvalid}, 32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
    endtask

    task automatic write_burst(input vec_t v, input int b);
        logic [31:0] a;
        logic [31:0] d;
        a = BASE + 32'(b * BL * 4);
        wait_for("awvalid", 0);
        if (tmo) return;
        if (v.stall) repeat ($urandom_range(0, 5)) begin
            chk("awaddr_stall", axi.awaddr, a);
            @(negedge clk);
        end
        chk("awaddr", axi.awaddr, a);
        chk("awlen", {24'd0, axi.awlen}, BL - 1);
        chk("awburst_awid", {26'd0, axi.awburst, axi.awid}, 32'h13);
        axi.awready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        for (int i = 0; i < BL; i++) begin
            d = exp_q.pop_front();
            wait_for("wvalid", 1);
            if (tmo) return;
            if (v.stall) repeat ($urandom_range(0, 5)) begin
                chk("wdata_stall", axi.wdata, d);
                @(negedge clk);
            end
            chk("wdata", axi.wdata, d);
            chk("wlast", {31'd0, axi.wlast}, (i == BL - 1) ? 32'd1 : 32'd0);
            chk("wstrb", {28'd0, axi.wstrb}, 32'hF);
            axi.wready = 1'b1;
            @(negedge clk);
            axi.wready = 1'b0;
        end
        if (v.stall) repeat ($urandom_range(0, 5)) @(negedge clk);
        axi.bresp  = (b == v.bresp_burst) ? 2'b10 : 2'b00;
        axi.bvalid = 1'b1;
        chk("bready", {31'd0, axi.bready}, 32'd1);
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
    endtask

    task automatic read_burst(input vec_t v, input int b);
        logic [31:0] a;
        int g;
        a = BASE + 32'(b * BL * 4);
        wait_for("arvalid", 2);
        if (tmo) return;
        if (v.stall) repeat ($urandom_range(0, 5)) begin
            chk("araddr_stall", axi.araddr, a);
            @(negedge clk);
        end
        chk("araddr", axi.araddr, a);
        chk("arlen", {24'd0, axi.arlen}, BL - 1);
        chk("arburst_arid", {26'd0, axi.arburst, axi.arid}, 32'h13);
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        for (int i = 0; i < BL; i++) begin
            g = b * BL + i;
            wait_for("rready", 3);
            if (tmo) return;
            if (v.stall) repeat ($urandom_range(0, 5)) @(negedge clk);
            axi.rdata  = pat(a + 32'(4 * i)) ^ ((g == v.corrupt) ? 32'd1 : 32'd0);
            axi.rresp  = (g == v.rresp_beat) ? 2'b11 : 2'b00;
            axi.rlast  = (i == BL - 1) ^ (g == v.rlast_flip);
            axi.rvalid = 1'b1;
            @(negedge clk);
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            axi.rresp  = 2'b00;
        end
    endtask

    // scoreboard: expected write beats are queued from the pattern model, consumed per beat
    task automatic serve(input vec_t v);
        tmo = 1'b0;
        exp_q.delete();
        for (int g = 0; g < NB * BL; g++) exp_q.push_back(pat(BASE + 32'(4 * g)));
        for (int b = 0; b < NB && !tmo; b++) write_burst(v, b);
        for (int b = 0; b < NB && !tmo; b++) read_burst(v, b);
        wait_for("done", 4);
        chk("err_count", {16'd0, err_count}, {16'd0, v.exp_err});
        chk("first_err_addr", first_err_addr, v.exp_first);
        chk("pass", {31'd0, pass}, {31'd0, v.exp_pass});
        chk("done_busy", {30'd0, done, busy}, 32'd2);
        chk("idle_valids", {28'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 32'd0);
        if (tmo) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic pulse_start_while_busy();
        foreach (vecs[k]) begin
            if (k < 3) begin
                repeat (2 + 3 * k) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'h3;
        axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rdata = 32'd0; axi.rid = 4'h3;

        //              stall corrupt bresp rresp rlast  err    first          pass
        vecs[0] = '{1'b0, -1, -1, -1, -1, 16'd0, 32'h0000_0000, 1'b1};
        vecs[1] = '{1'b0,  5, -1, -1, -1, 16'd1, 32'h0000_0114, 1'b0};
        vecs[2] = '{1'b1, -1, -1, -1, -1, 16'd0, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, -1,  1,  6, -1, 16'd2, 32'h0000_0110, 1'b0};
        vecs[4] = '{1'b1, -1, -1, -1,  1, 16'd1, 32'h0000_0104, 1'b0};
        vecs[5] = '{1'b0, -1, -1, -1,  7, 16'd1, 32'h0000_011C, 1'b0};
        vecs[6] = '{1'b0,  3, -1,  3, -1, 16'd1, 32'h0000_010C, 1'b0};
        vecs[7] = '{1'b1,  7, -1, -1,  7, 16'd2, 32'h0000_011C, 1'b0};
        clean_v = vecs[0];

        repeat (3) @(negedge clk);
        chk("rst_status", {27'd0, busy, done, pass, dbg_state[1:0]}, 32'd0);
        chk("rst_dbg_state", {29'd0, dbg_state}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_first_err", first_err_addr, 32'd0);
        chk("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // first good wdata hand-derived: 0x100 ^ 0xA5A55A5A
        chk("pattern_model", pat(BASE), 32'hA5A5_5B5A);

        foreach (vecs[k]) begin
            do_start();
            serve(vecs[k]);
        end

        // start pulses while busy must not launch a second test
        do_start();
        fork
            serve(clean_v);
            pulse_start_while_busy();
        join
        repeat (10) @(negedge clk);
        chk("after_ignored_start_state", {29'd0, dbg_state}, 32'd6);
        chk("after_ignored_start_awvalid", {31'd0, axi.awvalid}, 32'd0);

        // asynchronous reset out of DONE with a recorded error
        do_start();
        serve(vecs[1]);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_done", {30'd0, done, pass}, 32'd0);
        chk("async_rst_err", {16'd0, err_count}, 32'd0);
        chk("async_rst_first", first_err_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // asynchronous reset in the middle of a write burst
        do_start();
        axi.awready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        chk("mid_wdata_wvalid", {31'd0, axi.wvalid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valids", {30'd0, axi.wvalid, axi.awvalid}, 32'd0);
        chk("mid_rst_status", {29'd0, busy, done, pass}, 32'd0);
        chk("mid_rst_err", {16'd0, err_count}, 32'd0);
        chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        serve(clean_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
